// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared memory
// with a req/ready handshake, datapath strobes, retire counter and sticky errors.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic             reg_dst,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [7:0]       WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     cur;
  state_t     nxt;
  logic [7:0] wait_cnt;
  logic       retire;
  logic       mem_expired;
  logic       waiting;

  logic is_r, is_beq, is_lw, is_sw, is_j, is_slti, is_ori, is_addi, is_lui, legal;

  always_comb begin
    is_r    = (opcode == 6'b000000) || (opcode == 6'b001000);
    is_beq  = (opcode == 6'b000001) || (opcode == 6'b001001);
    is_lw   = (opcode == 6'b000010);
    is_sw   = (opcode == 6'b000011);
    is_j    = (opcode == 6'b000100);
    is_slti = (opcode == 6'b000110);
    is_ori  = (opcode == 6'b000111);
    is_addi = (opcode == 6'b001010);
    is_lui  = (opcode == 6'b101010);
    legal   = is_r | is_beq | is_lw | is_sw | is_j | is_slti | is_ori | is_addi | is_lui;
  end

  // The limit cycle itself counts as a wait; a ready in that cycle still completes.
  assign waiting     = ((cur == S_FETCH) || (cur == S_MEM)) && !mem_ready;
  assign mem_expired = waiting && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    nxt         = cur;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    mdr_we      = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'b00;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    wb_sel      = 2'b00;
    case (cur)
      S_IDLE: begin
        if (run) nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end else if (mem_expired) begin
          nxt = S_HALT;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          nxt = S_HALT;
        end else if (is_j) begin
          pc_we  = 1'b1;
          pc_src = 2'b10;
          retire = 1'b1;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_imm = is_lw | is_sw | is_slti | is_ori | is_addi;
        if (is_beq) begin
          pc_we  = zero;
          pc_src = 2'b01;
          retire = 1'b1;
        end else if (is_lw || is_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req     = 1'b1;
        addr_sel    = 1'b1;
        alu_src_imm = 1'b1;
        mem_we      = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            mdr_we = 1'b1;
            nxt    = S_WB;
          end else begin
            retire = 1'b1;
          end
        end else if (mem_expired) begin
          nxt = S_HALT;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = is_r;
        wb_sel  = is_lw ? 2'b01 : (is_lui ? 2'b10 : 2'b00);
        retire  = 1'b1;
      end
      S_HALT: begin
        nxt = S_HALT;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
    if (retire) nxt = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= S_IDLE;
      wait_cnt    <= 8'd0;
      instr_count <= '0;
      halted      <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cur <= nxt;
      // Any non-waiting cycle clears the counter, so every FETCH/MEM entry starts at 0.
      if (waiting) wait_cnt <= wait_cnt + 8'd1;
      else         wait_cnt <= 8'd0;
      if (retire) instr_count <= instr_count + CNT_ONE;
      if (nxt == S_HALT)             halted      <= 1'b1;
      if (cur == S_DECODE && !legal) err_illegal <= 1'b1;
      if (mem_expired)               err_timeout <= 1'b1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl plus hand sequences for
// illegal opcode, fetch timeout, async reset mid-access and counter wrap.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic [2:0]  state, state2;
  logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we;
  logic [1:0]  pc_src, wb_sel;
  logic        alu_src_imm, reg_we, reg_dst;
  logic        halted, err_illegal, err_timeout;
  logic [31:0] instr_count;

  logic        mem_req2, mem_we2, addr_sel2, ir_we2, mdr_we2, pc_we2;
  logic [1:0]  pc_src2, wb_sel2;
  logic        alu_src_imm2, reg_we2, reg_dst2;
  logic        halted2, err_illegal2, err_timeout2;
  logic [1:0]  instr_count2;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_imm(alu_src_imm),
    .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .halted(halted),
    .err_illegal(err_illegal), .err_timeout(err_timeout), .instr_count(instr_count)
  );

  // Narrow-counter copy on the same inputs, used to observe wrap-around.
  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state2), .mem_req(mem_req2), .mem_we(mem_we2), .addr_sel(addr_sel2), .ir_we(ir_we2),
    .mdr_we(mdr_we2), .pc_we(pc_we2), .pc_src(pc_src2), .alu_src_imm(alu_src_imm2),
    .reg_we(reg_we2), .reg_dst(reg_dst2), .wb_sel(wb_sel2), .halted(halted2),
    .err_illegal(err_illegal2), .err_timeout(err_timeout2), .instr_count(instr_count2)
  );

  // Strobe bundle: {mem_req,mem_we,addr_sel,ir_we,mdr_we,pc_we,pc_src[1:0],alu_src_imm,reg_we,reg_dst,wb_sel[1:0]}
  logic [12:0] strb;
  assign strb = {mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_src,
                 alu_src_imm, reg_we, reg_dst, wb_sel};

  localparam logic [12:0] NONE    = 13'h0000;
  localparam logic [12:0] F_WAIT  = 13'h1000; // mem_req
  localparam logic [12:0] F_RDY   = 13'h1280; // mem_req, ir_we, pc_we, pc_src=00
  localparam logic [12:0] J_DEC   = 13'h00C0; // pc_we, pc_src=10
  localparam logic [12:0] EX_IMM  = 13'h0010; // alu_src_imm
  localparam logic [12:0] BEQ_T   = 13'h00A0; // pc_we, pc_src=01
  localparam logic [12:0] BEQ_N   = 13'h0020; // pc_src=01
  localparam logic [12:0] MEM_LWW = 13'h1410; // mem_req, addr_sel, alu_src_imm
  localparam logic [12:0] MEM_LWR = 13'h1510; // + mdr_we
  localparam logic [12:0] MEM_SW  = 13'h1C10; // mem_req, mem_we, addr_sel, alu_src_imm
  localparam logic [12:0] WB_R    = 13'h000C; // reg_we, reg_dst, wb_sel=00
  localparam logic [12:0] WB_LW   = 13'h0009; // reg_we, wb_sel=01
  localparam logic [12:0] WB_LUI  = 13'h000A; // reg_we, wb_sel=10
  localparam logic [12:0] WB_I    = 13'h0008; // reg_we

  localparam logic [5:0] OP_R = 6'b000000, OP_BEQ = 6'b000001, OP_LW = 6'b000010,
                         OP_SW = 6'b000011, OP_J = 6'b000100, OP_ADDI = 6'b001010,
                         OP_LUI = 6'b101010, OP_BAD = 6'b111111;

  typedef struct {
    logic        run;
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [2:0]  st;
    logic [12:0] strb;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt[$];
  int   total = 0;
  int   passed = 0;

  function automatic vec_t mkv(logic r, logic [5:0] o, logic z, logic rd,
                               logic [2:0] s, logic [12:0] sb, logic [31:0] c);
    vec_t v;
    v.run = r; v.op = o; v.zero = z; v.rdy = rd; v.st = s; v.strb = sb; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // R, lw with 3 waits, sw, beq taken/not, j, lui, addi with run dropped in EXEC
    vt.push_back(mkv(1, OP_R,    0, 1, 3'd0, NONE,    0));
    vt.push_back(mkv(1, OP_R,    0, 1, 3'd1, F_RDY,   0));
    vt.push_back(mkv(1, OP_R,    0, 1, 3'd2, NONE,    0));
    vt.push_back(mkv(1, OP_R,    0, 1, 3'd3, NONE,    0));
    vt.push_back(mkv(1, OP_R,    0, 1, 3'd5, WB_R,    0));
    vt.push_back(mkv(1, OP_LW,   0, 1, 3'd1, F_RDY,   1));
    vt.push_back(mkv(1, OP_LW,   0, 1, 3'd2, NONE,    1));
    vt.push_back(mkv(1, OP_LW,   0, 0, 3'd3, EX_IMM,  1));
    vt.push_back(mkv(1, OP_LW,   0, 0, 3'd4, MEM_LWW, 1));
    vt.push_back(mkv(1, OP_LW,   0, 0, 3'd4, MEM_LWW, 1));
    vt.push_back(mkv(1, OP_LW,   0, 0, 3'd4, MEM_LWW, 1));
    vt.push_back(mkv(1, OP_LW,   0, 1, 3'd4, MEM_LWR, 1));
    vt.push_back(mkv(1, OP_LW,   0, 1, 3'd5, WB_LW,   1));
    vt.push_back(mkv(1, OP_SW,   0, 1, 3'd1, F_RDY,   2));
    vt.push_back(mkv(1, OP_SW,   0, 1, 3'd2, NONE,    2));
    vt.push_back(mkv(1, OP_SW,   0, 1, 3'd3, EX_IMM,  2));
    vt.push_back(mkv(1, OP_SW,   0, 1, 3'd4, MEM_SW,  2));
    vt.push_back(mkv(1, OP_BEQ,  1, 1, 3'd1, F_RDY,   3));
    vt.push_back(mkv(1, OP_BEQ,  1, 1, 3'd2, NONE,    3));
    vt.push_back(mkv(1, OP_BEQ,  1, 1, 3'd3, BEQ_T,   3));
    vt.push_back(mkv(1, OP_BEQ,  0, 1, 3'd1, F_RDY,   4));
    vt.push_back(mkv(1, OP_BEQ,  0, 1, 3'd2, NONE,    4));
    vt.push_back(mkv(1, OP_BEQ,  0, 1, 3'd3, BEQ_N,   4));
    vt.push_back(mkv(1, OP_J,    0, 1, 3'd1, F_RDY,   5));
    vt.push_back(mkv(1, OP_J,    0, 1, 3'd2, J_DEC,   5));
    vt.push_back(mkv(1, OP_LUI,  0, 1, 3'd1, F_RDY,   6));
    vt.push_back(mkv(1, OP_LUI,  0, 1, 3'd2, NONE,    6));
    vt.push_back(mkv(1, OP_LUI,  0, 1, 3'd3, NONE,    6));
    vt.push_back(mkv(1, OP_LUI,  0, 1, 3'd5, WB_LUI,  6));
    vt.push_back(mkv(1, OP_ADDI, 0, 1, 3'd1, F_RDY,   7));
    vt.push_back(mkv(1, OP_ADDI, 0, 1, 3'd2, NONE,    7));
    vt.push_back(mkv(0, OP_ADDI, 0, 1, 3'd3, EX_IMM,  7));
    vt.push_back(mkv(0, OP_ADDI, 0, 1, 3'd5, WB_I,    7));
    vt.push_back(mkv(0, OP_ADDI, 0, 1, 3'd0, NONE,    8));
    vt.push_back(mkv(0, OP_ADDI, 0, 1, 3'd0, NONE,    8));

    do_reset();
    #1;
    chk("reset_state", {61'd0, state}, 64'd0);
    chk("reset_strb", {51'd0, strb}, 64'd0);
    chk("reset_flags", {61'd0, halted, err_illegal, err_timeout}, 64'd0);
    chk("reset_count", {32'd0, instr_count}, 64'd0);

    for (int i = 0; i < vt.size(); i++) begin
      run = vt[i].run; opcode = vt[i].op; zero = vt[i].zero; mem_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d", i), {16'd0, state, strb, instr_count},
          {16'd0, vt[i].st, vt[i].strb, vt[i].cnt});
      chk($sformatf("vec%0d_wrapcnt", i), {62'd0, instr_count2}, {62'd0, vt[i].cnt[1:0]});
      step();
    end
    #1;
    chk("no_flags_after_vectors", {61'd0, halted, err_illegal, err_timeout}, 64'd0);

    // Illegal opcode halts; run/mem_ready activity cannot leave HALT
    do_reset();
    run = 1'b1; opcode = OP_BAD; mem_ready = 1'b1;
    step(); step(); step();
    #1;
    chk("illegal_state", {61'd0, state}, 64'd6);
    chk("illegal_flags", {61'd0, halted, err_illegal, err_timeout}, {61'd0, 3'b110});
    chk("illegal_strb", {51'd0, strb}, 64'd0);
    for (int k = 0; k < 6; k++) begin
      run = k[0]; mem_ready = ~k[0]; opcode = OP_R;
      step();
    end
    #1;
    chk("halt_sticky_state", {61'd0, state}, 64'd6);
    chk("halt_sticky_flag", {63'd0, halted}, 64'd1);
    do_reset();
    #1;
    chk("reset_clears_halt", {59'd0, state, halted, err_illegal}, 64'd0);

    // Fetch timeout: 15 cycles of mem_ready=0 halts
    run = 1'b1; mem_ready = 1'b0; opcode = OP_R;
    step();
    for (int k = 0; k < 14; k++) step();
    #1;
    chk("timeout_pre_state", {61'd0, state}, 64'd1);
    chk("timeout_pre_strb", {51'd0, strb}, {51'd0, F_WAIT});
    step();
    #1;
    chk("timeout_state", {61'd0, state}, 64'd6);
    chk("timeout_flags", {61'd0, halted, err_illegal, err_timeout}, {61'd0, 3'b101});

    // Ready on the 15th cycle wins over the timeout
    do_reset();
    run = 1'b1; mem_ready = 1'b0; opcode = OP_R;
    step();
    for (int k = 0; k < 14; k++) step();
    mem_ready = 1'b1;
    #1;
    chk("ready_at_limit_strb", {51'd0, strb}, {51'd0, F_RDY});
    step();
    #1;
    chk("ready_at_limit_state", {61'd0, state}, 64'd2);
    chk("ready_at_limit_flags", {61'd0, halted, err_illegal, err_timeout}, 64'd0);

    // Async reset while lw is waiting in MEM
    do_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = OP_LW;
    step(); step(); step();
    mem_ready = 1'b0;
    step();
    #1;
    chk("mem_wait_req", {60'd0, state, mem_req}, {60'd0, 3'd4, 1'b1});
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", {60'd0, state, mem_req}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
